// File: rtl/sram_byte_stream_ctrl.sv
// Byte-serial host controller for a 1RW SRAM macro with byte write mask.
// Define SRAM_STREAM_PREFETCH_EN to add a one-word read cache.
module sram_byte_stream_ctrl #(
    parameter int WORD_BYTES  = 4,
    parameter int WORD_ADDR_W = 9,
    parameter int PTR_W       = WORD_ADDR_W + $clog2(WORD_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    input  logic [1:0]              cmd_op,
    input  logic [7:0]              cmd_data,
    output logic                    cmd_ready,
    output logic [7:0]              rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [PTR_W-1:0]        ptr,
    output logic                    ram_clk0,
    output logic                    ram_csb0,
    output logic                    ram_web0,
    output logic [WORD_BYTES-1:0]   ram_wmask0,
    output logic [WORD_ADDR_W-1:0]  ram_addr0,
    output logic [8*WORD_BYTES-1:0] ram_din0,
    input  logic [8*WORD_BYTES-1:0] ram_dout0
);

    localparam int LANE_W = $clog2(WORD_BYTES);
    localparam int LW     = (LANE_W > 0) ? LANE_W : 1;
    localparam int DW     = 8 * WORD_BYTES;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_ISSUE = 2'd1;
    localparam logic [1:0] RD_WAIT  = 2'd2;
    localparam logic [1:0] RD_HOLD  = 2'd3;

    localparam logic [1:0] OP_SET_LO = 2'd0;
    localparam logic [1:0] OP_SET_HI = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic [1:0] OP_READ   = 2'd3;

    logic [1:0]             state;
    logic [LW-1:0]          rd_lane;
    logic [WORD_ADDR_W-1:0] word;
    logic [LW-1:0]          lane;
    logic [WORD_BYTES-1:0]  lane_mask;
    logic [7:0]             ram_byte;
    logic                   accept;

    assign ram_clk0  = clk;
    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign word      = WORD_ADDR_W'(ptr >> LANE_W);
    assign lane      = LW'(ptr & PTR_W'(WORD_BYTES - 1));
    assign lane_mask = WORD_BYTES'(1) << lane;
    assign ram_byte  = 8'(ram_dout0 >> {rd_lane, 3'b000});

`ifdef SRAM_STREAM_PREFETCH_EN
    logic [DW-1:0]          cache_data;
    logic [WORD_ADDR_W-1:0] cache_tag;
    logic                   cache_valid;
    logic                   hit;
    logic [7:0]             cache_byte;

    assign hit        = cache_valid && (cache_tag == word);
    assign cache_byte = 8'(cache_data >> {lane, 3'b000});
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            rd_lane    <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            ram_csb0   <= 1'b1;
            ram_web0   <= 1'b1;
            ram_wmask0 <= '0;
            ram_addr0  <= '0;
            ram_din0   <= '0;
`ifdef SRAM_STREAM_PREFETCH_EN
            cache_data  <= '0;
            cache_tag   <= '0;
            cache_valid <= 1'b0;
`endif
        end else begin
            // The port is idle unless an access is launched this edge.
            ram_csb0   <= 1'b1;
            ram_web0   <= 1'b1;
            ram_wmask0 <= '0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (cmd_op)
                            OP_SET_LO: ptr[7:0] <= cmd_data;
                            OP_SET_HI: ptr[PTR_W-1:8] <= cmd_data[PTR_W-9:0];
                            OP_WRITE: begin
                                ram_csb0   <= 1'b0;
                                ram_web0   <= 1'b0;
                                ram_wmask0 <= lane_mask;
                                ram_addr0  <= word;
                                ram_din0   <= {WORD_BYTES{cmd_data}};
                                ptr        <= ptr + 1'b1;
`ifdef SRAM_STREAM_PREFETCH_EN
                                if (hit) cache_valid <= 1'b0;
`endif
                            end
                            OP_READ: begin
                                ptr     <= ptr + 1'b1;
                                rd_lane <= lane;
`ifdef SRAM_STREAM_PREFETCH_EN
                                if (hit) begin
                                    rd_data  <= cache_byte;
                                    rd_valid <= 1'b1;
                                    state    <= RD_HOLD;
                                end else begin
                                    ram_csb0  <= 1'b0;
                                    ram_addr0 <= word;
                                    state     <= RD_ISSUE;
                                end
`else
                                ram_csb0  <= 1'b0;
                                ram_addr0 <= word;
                                state     <= RD_ISSUE;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    rd_data  <= ram_byte;
                    rd_valid <= 1'b1;
                    state    <= RD_HOLD;
`ifdef SRAM_STREAM_PREFETCH_EN
                    // ram_addr0 still holds the word just read.
                    cache_data  <= ram_dout0;
                    cache_tag   <= ram_addr0;
                    cache_valid <= 1'b1;
`endif
                end
                RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sram_byte_stream_ctrl.md
Name: sram_byte_stream_ctrl

Overview:
- Byte-serial host controller for a single-port 1RW SRAM macro with a byte-granular write mask.
- Host loads a byte pointer, then streams write or read bytes; the pointer auto-increments after each data byte.
- Reads return through a valid/ready holding register.
- Sits between the tile I/O command decoder and the SRAM macro, generalising the fixed 4-byte/32-bit word layout to parametrised word and depth.

Parameters:
- WORD_BYTES, 4: bytes per SRAM word; power of two, 1..8.
- WORD_ADDR_W, 9: SRAM word-address width.
- PTR_W, WORD_ADDR_W+$clog2(WORD_BYTES): byte-pointer width, ≤16; derived, do not override.

Ports:
- clk  in  1  system clock; also drives the SRAM.
- rst  in  1  asynchronous reset, active high.
- cmd_valid  in  1  command present.
- cmd_op  in  2  0=SET_LO, 1=SET_HI, 2=WRITE, 3=READ.
- cmd_data  in  8  pointer byte or write byte; ignored for READ.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at a clk edge.
- rd_data  out  8  read byte.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  host consumes rd_data.
- ptr  out  PTR_W  current byte pointer, for debug.
- ram_clk0  out  1  = clk.
- ram_csb0  out  1  chip select, active low.
- ram_web0  out  1  write enable, active low.
- ram_wmask0  out  WORD_BYTES  byte write mask.
- ram_addr0  out  WORD_ADDR_W  word address.
- ram_din0  out  8*WORD_BYTES  write data.
- ram_dout0  in  8*WORD_BYTES  read data, valid the cycle after a read is sampled.

Behaviour:
- Reset (async): state=IDLE, ptr=0, rd_data=0, rd_valid=0, ram_csb0=1, ram_web0=1, ram_wmask0=0, ram_addr0=0, ram_din0=0.
  - Any in-flight SRAM access is abandoned.
- Decomposition: word = ptr[PTR_W-1:log2(WORD_BYTES)]; lane = ptr[log2(WORD_BYTES)-1:0].
- States: IDLE, RD_ISSUE, RD_WAIT, RD_HOLD.
- cmd_ready = (state==IDLE).
- SET_LO: ptr[7:0]=cmd_data.
- SET_HI: ptr[PTR_W-1:8]=cmd_data[PTR_W-9:0]. Bits beyond PTR_W are ignored. No SRAM access.
- WRITE, accepted at edge E0: SRAM outputs are registered and driven for exactly the cycle after E0:
  - csb=0, web=0, wmask=one-hot(lane), addr=word, din=cmd_data replicated in every lane.
  - ptr increments at E0.
  - State stays IDLE, so back-to-back writes run at one byte per cycle.
- READ, accepted at E0: ptr latched for the access, ptr increments at E0, state→RD_ISSUE.
  - RD_ISSUE (cycle after E0): csb=0, web=1, wmask=0, addr=word. → RD_WAIT.
  - RD_WAIT: ram_dout0 valid. At edge E2, rd_data=ram_dout0[8*lane +: 8], rd_valid=1. → RD_HOLD.
  - RD_HOLD: while rd_valid&&rd_ready at an edge: rd_valid=0, → IDLE. rd_data holds its value until replaced.
- SRAM idle: csb=1, web=1, wmask=0 in every cycle with no access.
  - addr/din hold their last value.
- Write then READ: the write occupies the cycle after its accept edge and the read issues one cycle later, so there is no port conflict.
- Pointer wrap: ptr = 2^PTR_W-1 increments to 0 silently.
- cmd_op WRITE while state≠IDLE: not accepted; the host must hold the command.

Optional Feature:
- Macro SRAM_STREAM_PREFETCH_EN.
- Defined: a one-word read cache (word register + tag + valid bit).
  - RD_WAIT loads the cache with ram_dout0 and tag=word.
  - A READ whose word equals the tag with valid=1 is a hit. A hit sets rd_data from the cache lane at the accept edge, rd_valid=1, →RD_HOLD, with no SRAM access (latency 1 edge vs 3).
  - An accepted WRITE to the cached word clears valid. Reset clears valid.
  - SET_LO/SET_HI do not invalidate.
- Undefined: every READ accesses the SRAM; no cache logic exists.

Test Plan:
- Reset: assert rst mid-RD_WAIT → same cycle ram_csb0=1, rd_valid=0. After release, ptr=0 and cmd_ready=1.
- Write burst: SET_LO 0x04, SET_HI 0x00, then WRITE 0xA1,0xB2,0xC3,0xD4 on consecutive cycles → four SRAM cycles at addr=1 with wmask 0001,0010,0100,1000 and lane data as given; ptr=8 after.
- Read stream: SET_LO 0x05, READ, rd_ready=1 → rd_valid rises 3 edges after accept, rd_data=0xB2. Next READ returns 0xC3 and ptr=7.
- Backpressure: hold rd_ready=0 for 5 cycles → rd_valid and rd_data stable, cmd_ready=0, no SRAM access. Release → one handshake, then IDLE.
- Wrap: set ptr=0x7FF (default), WRITE 0x5A → addr=511, wmask=1000, ptr=0.
- Prefetch (macro on): READ at 0x04 then 0x05 → second read makes no SRAM access, rd_valid 1 edge after accept. WRITE to 0x06, then READ 0x06 → SRAM access occurs and returns the new byte.
